mor1kx_dpram_be_clr_sclk: RTL and testbench

MOR1KX_DPRAM_BE_CLR_SCLK -- requirements
Module: mor1kx_dpram_be_clr_sclk

---
 rtl/mor1kx_dpram_be_clr_sclk.sv | 139 +++++++++++++
 tb/tb_mor1kx_dpram_be_clr_sclk.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mor1kx_dpram_be_clr_sclk.sv
// Single-clock dual-port RAM with byte enables, write-to-read forwarding and
// an optional sequencer that clears every word after reset or on request.
module mor1kx_dpram_be_clr_sclk #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ENABLE_BYPASS = 1,
  parameter int ENABLE_HW_CLEAR = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  output logic                      busy,
  input  logic [ADDR_WIDTH-1:0]     raddr,
  input  logic                      re,
  input  logic [ADDR_WIDTH-1:0]     waddr,
  input  logic                      we,
  input  logic [DATA_WIDTH/8-1:0]   wbe,
  input  logic [DATA_WIDTH-1:0]     din,
  output logic [DATA_WIDTH-1:0]     dout
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int DEPTH    = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_busy;
  logic                  w_clr_we;
  logic [ADDR_WIDTH-1:0] w_clr_addr;

  generate
    if (ENABLE_HW_CLEAR != 0) begin : g_clr
      typedef enum logic {S_IDLE, S_CLEAR} state_t;
      state_t                r_state;
      state_t                w_state_next;
      logic [ADDR_WIDTH-1:0] r_cnt;
      logic [ADDR_WIDTH-1:0] w_cnt_next;
      logic                  r_busy;

      always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
          S_IDLE: begin
            if (clear) begin
              w_state_next = S_CLEAR;
              w_cnt_next   = '0;
            end
          end
          S_CLEAR: begin
            // clear requests here are deliberately ignored
            w_cnt_next = r_cnt + ADDR_WIDTH'(1);
            if (r_cnt == {ADDR_WIDTH{1'b1}}) begin
              w_state_next = S_IDLE;
            end
          end
          default: w_state_next = S_IDLE;
        endcase
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_state <= S_CLEAR;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
        end else begin
          r_state <= w_state_next;
          r_cnt   <= w_cnt_next;
          r_busy  <= (w_state_next == S_CLEAR);
        end
      end

      // The edge that samples rst only restarts the count; it writes nothing.
      assign w_clr_we   = (r_state == S_CLEAR) && !rst;
      assign w_clr_addr = r_cnt;
      assign w_busy     = r_busy;
    end else begin : g_noclr
      assign w_clr_we   = 1'b0;
      assign w_clr_addr = '0;
      assign w_busy     = 1'b0;
    end
  endgenerate

  assign busy = w_busy;

  logic                  w_user_we;
  logic                  w_rd_en;
  logic                  w_fwd_hit;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_data;
  logic [BE_WIDTH-1:0]   w_mem_be;

  assign w_user_we  = we && !w_busy && !rst;
  assign w_rd_en    = re && !w_busy && !rst;
  assign w_fwd_hit  = (ENABLE_BYPASS != 0) && w_user_we && (raddr == waddr);

  // The sequencer and the user port never write in the same cycle (busy gates the user).
  assign w_mem_we   = w_clr_we || w_user_we;
  assign w_mem_addr = w_clr_we ? w_clr_addr : waddr;
  assign w_mem_data = w_clr_we ? CLEAR_VALUE : din;
  assign w_mem_be   = w_clr_we ? {BE_WIDTH{1'b1}} : wbe;

  always_ff @(posedge clk) begin
    for (int b = 0; b < BE_WIDTH; b++) begin
      if (w_mem_we && w_mem_be[b]) begin
        r_mem[w_mem_addr][b*8 +: 8] <= w_mem_data[b*8 +: 8];
      end
    end
  end

  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_fwd_data;
  logic [BE_WIDTH-1:0]   r_fwd_mask;
  logic [DATA_WIDTH-1:0] w_fwd_bits;

  // Read sees pre-write contents; forwarded bytes are merged at the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata    <= '0;
      r_fwd_data <= '0;
      r_fwd_mask <= '0;
    end else if (w_rd_en) begin
      r_rdata    <= r_mem[raddr];
      r_fwd_data <= din;
      r_fwd_mask <= w_fwd_hit ? wbe : '0;
    end
  end

  generate
    for (genvar gi = 0; gi < BE_WIDTH; gi++) begin : g_fwd_bits
      assign w_fwd_bits[gi*8 +: 8] = {8{r_fwd_mask[gi]}};
    end
  endgenerate

  assign dout = (r_rdata & ~w_fwd_bits) | (r_fwd_data & w_fwd_bits);

endmodule

// File: tb/tb_mor1kx_dpram_be_clr_sclk.sv
// Randomized self-checking bench for mor1kx_dpram_be_clr_sclk (16 x 32 bits).
module tb_mor1kx_dpram_be_clr_sclk;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          busy;
  logic [AW-1:0] raddr = '0;
  logic          re = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic          we = 1'b0;
  logic [3:0]    wbe = '0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;

  int checks = 0;
  int errors = 0;

  // Reference model: word array, expected dout, remaining busy cycles.
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] dout_m = '0;
  int            busy_left = 0;

  mor1kx_dpram_be_clr_sclk #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .ENABLE_BYPASS(1),
    .ENABLE_HW_CLEAR(1),
    .CLEAR_VALUE(32'h0)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .busy(busy),
    .raddr(raddr), .re(re), .waddr(waddr), .we(we),
    .wbe(wbe), .din(din), .dout(dout)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [3:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  // Advance the model by one clock using the current inputs, then clock the DUT.
  task automatic tick();
    logic [DW-1:0] rd;
    if (rst) begin
      dout_m    = '0;
      busy_left = DEPTH;
    end else if (busy_left > 0) begin
      mem_m[DEPTH - busy_left] = 32'h0;
      busy_left--;
    end else begin
      if (re) begin
        rd = mem_m[raddr];
        if (we && raddr == waddr) rd = merge(rd, din, wbe);
        dout_m = rd;
      end
      if (we) mem_m[waddr] = merge(mem_m[waddr], din, wbe);
      if (clear) busy_left = DEPTH;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; clear = 0; re = 0; we = 0; wbe = '0;
  endtask

  task automatic read_all_zero(input string tag);
    idle_inputs();
    for (int a = 0; a < DEPTH; a++) begin
      re = 1; raddr = AW'(a);
      tick();
      checks++;
      if (dout !== 32'h0 || dout_m !== 32'h0) begin
        errors++;
        $display("FAIL %s addr %0d: dout=%h required 00000000", tag, a, dout);
      end
    end
    re = 0;
  endtask

  task automatic test_reset();
    int n;
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if (busy !== 1'b1 || dout !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b dout=%h required busy=1 dout=0", busy, dout);
    end
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      checks++;
      if (dout !== 32'h0) begin
        errors++;
        $display("FAIL reset_dout_busy: dout=%h required 0", dout);
      end
      re = 1; raddr = AW'($urandom_range(0, DEPTH-1));
      n++;
      tick();
    end
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL reset_busy_len: busy cycles=%0d required %0d", n, DEPTH);
    end
    read_all_zero("reset_read");
  endtask

  task automatic test_byte_enable();
    idle_inputs();
    we = 1; waddr = 3; din = 32'h11223344; wbe = 4'b1111; tick();
    din = 32'hAABBCCDD; wbe = 4'b0101; tick();
    we = 0; re = 1; raddr = 3; tick();
    re = 0;
    checks++;
    if (dout !== 32'h11BB33DD || dout_m !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL byte_enable: dout=%h required 11bb33dd", dout);
    end
  endtask

  task automatic test_bypass();
    idle_inputs();
    we = 1; waddr = 5; din = 32'h0; wbe = 4'b1111; tick();
    re = 1; raddr = 5; din = 32'hDEADBEEF; wbe = 4'b1100; tick();
    checks++;
    if (dout !== 32'hDEAD0000) begin
      errors++;
      $display("FAIL bypass_forward: dout=%h required dead0000", dout);
    end
    we = 0; raddr = 5; tick();
    re = 0;
    checks++;
    if (dout !== 32'hDEAD0000) begin
      errors++;
      $display("FAIL bypass_stored: dout=%h required dead0000", dout);
    end
  endtask

  task automatic test_hold();
    idle_inputs();
    we = 1; waddr = 2; din = 32'h0000CAFE; wbe = 4'b1111; tick();
    we = 0; re = 1; raddr = 2; tick();
    re = 0; we = 1; waddr = 2; din = 32'h12345678; tick();
    we = 0; tick(); tick();
    checks++;
    if (dout !== 32'h0000CAFE || dout_m !== 32'h0000CAFE) begin
      errors++;
      $display("FAIL hold_no_re: dout=%h required 0000cafe", dout);
    end
    re = 1; raddr = 2; tick();
    re = 0;
    checks++;
    if (dout !== 32'h12345678) begin
      errors++;
      $display("FAIL hold_next_re: dout=%h required 12345678", dout);
    end
  endtask

  task automatic test_clear_ignore();
    int n;
    idle_inputs();
    for (int a = 0; a < DEPTH; a++) begin
      we = 1; waddr = AW'(a); din = $urandom | 32'h1; wbe = 4'b1111; tick();
    end
    we = 0; clear = 1; tick();
    clear = 0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      clear = (n == 5);
      we = 1; waddr = AW'($urandom_range(0, DEPTH-1)); din = $urandom | 32'h1; wbe = 4'b1111;
      n++;
      tick();
    end
    idle_inputs();
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL clear_busy_len: busy cycles=%0d required %0d", n, DEPTH);
    end
    read_all_zero("clear_read");
  endtask

  task automatic test_rst_mid_clear();
    int n;
    idle_inputs();
    for (int a = 0; a < DEPTH; a += 3) begin
      we = 1; waddr = AW'(a); din = 32'hA5A5A5A5; wbe = 4'b1111; tick();
    end
    we = 0; clear = 1; tick();
    clear = 0;
    for (int i = 0; i < 8; i++) tick();
    rst = 1; tick();
    rst = 0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL rst_mid_clear_len: busy cycles=%0d required %0d", n, DEPTH);
    end
    read_all_zero("rst_mid_read");
  endtask

  task automatic test_random();
    idle_inputs();
    for (int i = 0; i < 400; i++) begin
      re    = $urandom_range(0, 1);
      we    = $urandom_range(0, 1);
      raddr = AW'($urandom_range(0, 3));
      waddr = AW'($urandom_range(0, 3));
      wbe   = 4'($urandom);
      din   = $urandom;
      clear = ($urandom_range(0, 59) == 0);
      tick();
      checks++;
      if (dout !== dout_m || busy !== (busy_left > 0)) begin
        errors++;
        $display("FAIL random cycle %0d: dout=%h busy=%b required dout=%h busy=%b",
                 i, dout, busy, dout_m, (busy_left > 0));
      end
    end
    idle_inputs();
    while (busy_left > 0) tick();
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) mem_m[a] = '0;
    test_reset();
    test_byte_enable();
    test_bypass();
    test_hold();
    test_clear_ignore();
    test_rst_mid_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
